// File: rtl/mux_conf_sequencer.sv
// mux_conf_sequencer: initiator for the design-mux control interface.
// Holds designs in reset, clocks select/enables into the mux, then releases.
module mux_conf_sequencer #(
  parameter int CLK_HALF    = 2,
  parameter int CONF_PULSES = 3,
  parameter int RESET_HOLD  = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_sel,
  input  logic       req_sys_reset_enb,
  input  logic       req_auto_reset_enb,
  input  logic [7:0] req_design_reset,
  output logic       mux_conf_clk,
  output logic [3:0] o_mux_sel,
  output logic       o_mux_sys_reset_enb,
  output logic       o_mux_auto_reset_enb,
  output logic [7:0] o_design_reset,
  output logic       busy,
  output logic       done
);

  if (CLK_HALF < 1 || CLK_HALF > 255) begin : g_bad_half
    $error("mux_conf_sequencer: CLK_HALF out of range 1..255");
  end
  if (CONF_PULSES < 2 || CONF_PULSES > 15) begin : g_bad_pulses
    $error("mux_conf_sequencer: CONF_PULSES out of range 2..15");
  end
  if (RESET_HOLD < 0 || RESET_HOLD > 255) begin : g_bad_hold
    $error("mux_conf_sequencer: RESET_HOLD out of range 0..255");
  end

  localparam logic [7:0] HALF_LAST = 8'(CLK_HALF - 1);
  localparam logic [7:0] HOLD_LAST =
    (RESET_HOLD > 0) ? 8'(RESET_HOLD - 1) : 8'd0;
  localparam logic [3:0] PULSE_CNT = 4'(CONF_PULSES);
  localparam bit         NO_HOLD   = (RESET_HOLD == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLK_LO,
    S_CLK_HI,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] phase, phase_n;
  logic [3:0] pulse, pulse_n;
  logic [3:0] pulse_inc;
  logic [7:0] dr_cap, dr_cap_n;
  logic       cclk_n;
  logic [3:0] sel_n;
  logic       sys_n, auto_n;
  logic [7:0] dr_n;
  logic       busy_n, done_n;

  assign req_ready = (state == S_IDLE);
  assign pulse_inc = pulse + 4'd1;

  // Register state and every output so nothing leaks combinationally.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state                <= S_IDLE;
      phase                <= 8'd0;
      pulse                <= 4'd0;
      dr_cap               <= 8'h00;
      mux_conf_clk         <= 1'b0;
      o_mux_sel            <= 4'd0;
      o_mux_sys_reset_enb  <= 1'b1;
      o_mux_auto_reset_enb <= 1'b1;
      o_design_reset       <= 8'h00;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      state                <= state_n;
      phase                <= phase_n;
      pulse                <= pulse_n;
      dr_cap               <= dr_cap_n;
      mux_conf_clk         <= cclk_n;
      o_mux_sel            <= sel_n;
      o_mux_sys_reset_enb  <= sys_n;
      o_mux_auto_reset_enb <= auto_n;
      o_design_reset       <= dr_n;
      busy                 <= busy_n;
      done                 <= done_n;
    end
  end

  // Next-state and next-output decode; hold everything unless changed.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    pulse_n  = pulse;
    dr_cap_n = dr_cap;
    cclk_n   = mux_conf_clk;
    sel_n    = o_mux_sel;
    sys_n    = o_mux_sys_reset_enb;
    auto_n   = o_mux_auto_reset_enb;
    dr_n     = o_design_reset;
    busy_n   = busy;
    done_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          dr_cap_n = req_design_reset;
          sel_n    = req_sel;
          sys_n    = req_sys_reset_enb;
          auto_n   = req_auto_reset_enb;
          dr_n     = 8'hFF;
          pulse_n  = 4'd0;
          phase_n  = 8'd0;
          busy_n   = 1'b1;
          state_n  = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        if (phase == HALF_LAST) begin
          phase_n = 8'd0;
          cclk_n  = 1'b1;
          state_n = S_CLK_HI;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      S_CLK_HI: begin
        if (phase == HALF_LAST) begin
          phase_n = 8'd0;
          cclk_n  = 1'b0;
          pulse_n = pulse_inc;
          if (pulse_inc < PULSE_CNT) begin
            state_n = S_CLK_LO;
          end else if (NO_HOLD) begin
            dr_n    = dr_cap;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_HOLD;
          end
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      S_HOLD: begin
        if (phase == HOLD_LAST) begin
          phase_n = 8'd0;
          dr_n    = dr_cap;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
